// File: rtl/uart_tx_frame.sv
// UART transmitter with runtime word length, parity and stop-bit selection.
// Tick is a clock enable only; everything runs on Clock.
module uart_tx_frame #(
    parameter int MAX_BITS   = 8,
    parameter int OVERSAMPLE = 16,
    parameter int NB_W       = $clog2(MAX_BITS + 1)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                Tx_valid,
    output logic                Tx_ready,
    input  logic [MAX_BITS-1:0] Message_in,
    input  logic [NB_W-1:0]     N_bits,
    input  logic [1:0]          Parity_mode,
    input  logic                Two_stop,
    output logic                Tx_out,
    output logic                Tx_busy,
    output logic                Tx_done
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       tick_q, tick_d;
    logic [NB_W-1:0]     bit_q, bit_d;
    logic [NB_W-1:0]     nbits_q, nbits_d;
    logic [MAX_BITS-1:0] shift_q, shift_d;
    logic                par_en_q, par_en_d;
    logic                par_q, par_d;
    logic                two_q, two_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;

    logic                accept;
    logic                bit_end;
    logic [NB_W-1:0]     nb_eff;
    logic                par_calc;

    assign accept  = Tx_valid && (state_q == IDLE);
    assign bit_end = Tick && (tick_q == CW'(OVERSAMPLE - 1));

    // Out-of-range word lengths fall back to the full width.
    always_comb begin
        nb_eff = N_bits;
        if (N_bits == '0 || N_bits > NB_W'(MAX_BITS))
            nb_eff = NB_W'(MAX_BITS);
    end

    always_comb begin
        par_calc = 1'b0;
        for (int i = 0; i < MAX_BITS; i++)
            if (NB_W'(i) < nb_eff)
                par_calc = par_calc ^ Message_in[i];
        if (Parity_mode == 2'b10)
            par_calc = ~par_calc;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            nbits_q  <= '0;
            shift_q  <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            two_q    <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            nbits_q  <= nbits_d;
            shift_q  <= shift_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            two_q    <= two_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        nbits_d  = nbits_q;
        shift_d  = shift_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        two_d    = two_q;
        tx_d     = tx_q;
        done_d   = 1'b0;

        if (state_q != IDLE && Tick)
            tick_d = bit_end ? '0 : tick_q + CW'(1);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d  = START;
                    tx_d     = 1'b0;
                    tick_d   = '0;
                    bit_d    = '0;
                    nbits_d  = nb_eff;
                    shift_d  = Message_in;
                    par_en_d = (Parity_mode == 2'b01) || (Parity_mode == 2'b10);
                    par_d    = par_calc;
                    two_d    = Two_stop;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == nbits_q - NB_W'(1)) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                        bit_d   = bit_q + NB_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            STOP: begin
                // bit_q counts stop bits already sent.
                if (bit_end) begin
                    if (two_q && bit_q == '0) begin
                        bit_d = NB_W'(1);
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        bit_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign Tx_out   = tx_q;
    assign Tx_ready = (state_q == IDLE);
    assign Tx_busy  = (state_q != IDLE);
    assign Tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frame contents, timing, handshake, sparse Tick, reset abort.
module tb_uart_tx_frame;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Tick = 1'b1;
    logic       Tx_valid;
    logic       Tx_ready;
    logic [7:0] Message_in;
    logic [3:0] N_bits;
    logic [1:0] Parity_mode;
    logic       Two_stop;
    logic       Tx_out;
    logic       Tx_busy;
    logic       Tx_done;

    int n_cmp = 0;
    int n_err = 0;
    int tick_div = 1;
    int tph = 0;
    int last_wait = 0;

    uart_tx_frame #(.MAX_BITS(8), .OVERSAMPLE(16)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Tick       (Tick),
        .Tx_valid   (Tx_valid),
        .Tx_ready   (Tx_ready),
        .Message_in (Message_in),
        .N_bits     (N_bits),
        .Parity_mode(Parity_mode),
        .Two_stop   (Two_stop),
        .Tx_out     (Tx_out),
        .Tx_busy    (Tx_busy),
        .Tx_done    (Tx_done)
    );

    always #5 Clock = ~Clock;

    // Tick changes on the falling edge so it is stable at every rising edge.
    always @(negedge Clock) begin
        tph  = (tph + 1) % tick_div;
        Tick = (tph == 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send one frame; exp holds the line levels per bit period, bit 0 = start bit.
    task automatic run_frame(input string tag, input logic [7:0] data, input logic [3:0] nb,
                             input logic [1:0] pm, input logic ts, input logic [15:0] exp,
                             input int nbit, input logic keep, input logic [7:0] nxt,
                             input int abort_tick);
        int w, k, ticks, nd;
        logic t, done_seen;
        logic [15:0] got, mask;
        Message_in  = data;
        N_bits      = nb;
        Parity_mode = pm;
        Two_stop    = ts;
        Tx_valid    = 1'b1;
        w = 0;
        while (!Tx_ready && w < 4000) begin
            @(posedge Clock); #1; w++;
        end
        last_wait = w;
        @(posedge Clock); #1;
        if (!keep) begin
            Tx_valid    = 1'b0;
            Message_in  = ~data;
            N_bits      = nb + 4'd1;
            Parity_mode = ~pm;
            Two_stop    = ~ts;
        end
        chk({tag, "_busy"}, Tx_busy, 1'b1);
        chk({tag, "_done_clr"}, Tx_done, 1'b0);
        ticks = 0; k = 0; got = '0; done_seen = 1'b0;
        while (!done_seen && k < 8000) begin
            @(posedge Clock);
            t = Tick;
            #1; k++;
            if (t) begin
                ticks++;
                if (ticks % 16 == 8 && ticks / 16 < 16) got[ticks / 16] = Tx_out;
            end
            if (keep && ticks == 40) Message_in = nxt;
            if (abort_tick != 0 && t && ticks == abort_tick) begin
                chk({tag, "_pre_low"}, Tx_out, 1'b0);
                #2 Reset = 1'b1;
                #1;
                chk({tag, "_rst_tx"}, Tx_out, 1'b1);
                chk({tag, "_rst_rdy"}, Tx_ready, 1'b1);
                chk({tag, "_rst_busy"}, Tx_busy, 1'b0);
                @(negedge Clock) Reset = 1'b0;
                nd = 0;
                repeat (20) begin
                    @(posedge Clock); #1;
                    if (Tx_done) nd++;
                end
                chk({tag, "_no_done"}, nd, 0);
                return;
            end
            if (Tx_done) done_seen = 1'b1;
        end
        mask = (16'd1 << nbit) - 16'd1;
        chk({tag, "_done"}, done_seen, 1'b1);
        chk({tag, "_bits"}, got & mask, exp & mask);
        chk({tag, "_ticks"}, ticks, nbit * 16);
        if (tick_div == 1) chk({tag, "_cycles"}, k, nbit * 16);
        chk({tag, "_rdy"}, Tx_ready, 1'b1);
        chk({tag, "_idle"}, Tx_out, 1'b1);
        if (!keep) begin
            @(posedge Clock); #1;
            chk({tag, "_pulse1"}, Tx_done, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Tx_valid = 1'b0; Message_in = '0;
        N_bits = '0; Parity_mode = '0; Two_stop = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_tx", Tx_out, 1'b1);
        chk("rst_rdy", Tx_ready, 1'b1);
        chk("rst_busy", Tx_busy, 1'b0);
        chk("rst_done", Tx_done, 1'b0);
        @(negedge Clock) Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;

        run_frame("8n1", 8'hA5, 4'd8, 2'b00, 1'b0, 16'b1101001010, 10, 1'b0, 8'h00, 0);
        run_frame("7e2", 8'h41, 4'd7, 2'b01, 1'b1, 16'b11010000010, 11, 1'b0, 8'h00, 0);
        run_frame("5o1", 8'h00, 4'd5, 2'b10, 1'b0, 16'b11000000, 8, 1'b0, 8'h00, 0);
        run_frame("nb0", 8'hFF, 4'd0, 2'b00, 1'b0, 16'b1111111110, 10, 1'b0, 8'h00, 0);

        run_frame("b2b1", 8'h55, 4'd8, 2'b00, 1'b0, 16'b1010101010, 10, 1'b1, 8'hC3, 0);
        run_frame("b2b2", 8'hC3, 4'd8, 2'b00, 1'b0, 16'b1110000110, 10, 1'b0, 8'h00, 0);
        chk("b2b_gap", last_wait, 0);

        tick_div = 4;
        run_frame("sparse", 8'h3C, 4'd8, 2'b00, 1'b0, 16'b1001111000, 10, 1'b0, 8'h00, 0);
        tick_div = 1;
        repeat (4) @(posedge Clock);
        #1;

        run_frame("rst", 8'hF0, 4'd8, 2'b00, 1'b0, 16'b0, 10, 1'b0, 8'h00, 3 * 16 + 8);
        run_frame("post", 8'h81, 4'd8, 2'b00, 1'b0, 16'b1100000010, 10, 1'b0, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the crypto accelerator's serial output path. It is the next generation of the fixed 8N1 transmitter and adds runtime word length, parity and stop-bit selection, plus a valid/ready byte handshake. The whole block runs on the system clock, and Tick is used only as a clock enable. It sits between the result-formatting logic and the Tx pin, fed by the shared baud-tick generator.

## Interface
Parameters:
- MAX_BITS, 8: maximum data bits per frame.
- OVERSAMPLE, 16: Tick pulses per serial bit period.
- NB_W, $clog2(MAX_BITS+1): width of N_bits.

Ports:
- Clock, input, 1: system clock, rising edge.
- Reset, input, 1: asynchronous, active-high.
- Tick, input, 1: baud-rate enable, one Clock cycle wide, sampled on Clock.
- Tx_valid, input, 1: Message_in and config are valid.
- Tx_ready, output, 1: block can accept a frame.
- Message_in, input, MAX_BITS: data word, sent LSB first.
- N_bits, input, NB_W: data bits per frame.
- Parity_mode, input, 2: 00 = none, 01 = even, 10 = odd, 11 = none.
- Two_stop, input, 1: 0 = one stop bit, 1 = two stop bits.
- Tx_out, output, 1: serial line, idle high.
- Tx_busy, output, 1: a frame is in progress.
- Tx_done, output, 1: one-cycle pulse when the last stop bit ends.

## Operation
- Accept happens on the Clock edge where Tx_valid && Tx_ready. At that edge the block latches Message_in, N_bits, Parity_mode and Two_stop into shadow registers. Inputs may change freely afterwards.
- N_bits of 0 or greater than MAX_BITS is treated as MAX_BITS.
- Parity is computed over the N_bits data bits only. Even parity is the XOR of those bits; odd parity is its inverse.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on accept.
  - START → DATA after one bit period.
  - DATA → PARITY after N_bits bit periods if parity is enabled, otherwise DATA → STOP.
  - PARITY → STOP after one bit period.
  - STOP → IDLE after 1 or 2 bit periods.
- Tx_out by state: 1 in IDLE, 0 in START, shift-register LSB in DATA, parity bit in PARITY, 1 in STOP.
- Bit period: a tick counter of width $clog2(OVERSAMPLE) is cleared on accept and on every bit boundary. It counts Tick pulses only. A bit ends on the Clock edge that samples the OVERSAMPLE-th Tick of that bit.
- Clock cycles without Tick hold all state.
- Tx_ready is 1 only in IDLE. Tx_busy is the inverse of Tx_ready.
- Back-to-back frames: Tx_ready is high in the cycle after Tx_done. If Tx_valid is already high, the next accept occurs on that edge. The gap between stop and start is exactly one Clock cycle of idle-high.
- Reset, asserted at any time including mid-frame, aborts the frame. The state returns to IDLE asynchronously. Reset values are Tx_out=1, Tx_ready=1, Tx_busy=0, Tx_done=0, and all counters and shadow registers 0.

## Timing
- Accept at edge E. Tx_out=0 is visible from E+1.
- The start bit lasts until the OVERSAMPLE-th Tick after E.
- With Tick high every cycle, each bit lasts exactly OVERSAMPLE Clock cycles.
- Frame length is (1 + N_bits + P + S) × OVERSAMPLE Tick pulses, where P is 0 or 1 for parity and S is 1 or 2 for stop bits.
- Tx_done is high for exactly the one cycle following the edge that ends the last stop bit.
- Tx_ready rises in that same cycle.
- Tx_out is registered, so there are no combinational paths from inputs to Tx_out.
- Tx_valid while busy is ignored. It is not queued and it is not an error.

## Test plan
- 8N1: OVERSAMPLE=16, Tick every cycle, 0xA5, N_bits=8, Parity_mode=00, Two_stop=0. Required response: Tx_out is 0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles. Tx_done pulses 160 cycles after E+1.
- 7E2: 0x41, N_bits=7, even parity. Required response: data bits 1,0,0,0,0,0,1, parity bit 0, two stop bits. Frame is 11 bit periods (176 cycles) and Tx_done fires once.
- 5O1: 0x00, N_bits=5, odd parity. Required response: parity bit 1. N_bits=0 with 0xFF sends 8 data bits, all 1.
- Back-to-back: Tx_valid held high with 0x55 then 0xC3. Required response: the second start bit begins exactly one idle cycle after Tx_done, and Message_in changes mid-frame do not corrupt the first frame.
- Sparse Tick: one Tick every 4 cycles, 8N1, 0x3C. Required response: each bit lasts 64 cycles and state holds between Ticks.
- Reset in the DATA state (third bit). Required response: Tx_out=1 and Tx_ready=1 immediately, Tx_done is not pulsed, and the next frame (0x81, 8N1) is transmitted correctly.
